ssd_scan_driver: RTL and testbench

- Parametrised, time-multiplexed hex seven-segment display driver for N digits.
- Generalises the current two-digit debug display, which is a fixed nibble mux driven off a free-running counter.
- Adds a valid/ready load port, tear-free frame-synchronous updates, decimal points, leading-zero blanking, global blanking and polarity selection.
- Sits between any byte/word producer (UART RX path, ALU FSM) and the board SSD pins.

---
 rtl/ssd_scan_driver.sv | 85 ++++++++
 tb/tb_ssd_scan_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed hex seven-segment driver with frame-synchronous valid/ready loading
module ssd_scan_driver #(
  parameter int NUM_DIGITS     = 2,
  parameter int SCAN_DIV       = 256,
  parameter int ACTIVE_LOW_SEG = 0,
  parameter int BLANK_LEADING  = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [4*NUM_DIGITS-1:0]            data_i,
  input  logic [NUM_DIGITS-1:0]              dp_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic                               blank_i,
  output logic [6:0]                         seg_o,
  output logic                               dp_o,
  output logic [NUM_DIGITS-1:0]              dig_sel_o,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] dig_idx_o
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [DW-1:0]           div;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_data, disp_data;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp, lz, sel;
  logic                    pend_full, wrap, frame_end, acc, blanked, dp;
  logic [3:0]              nib;
  logic [6:0]              seg;
  assign wrap      = div == DW'(SCAN_DIV - 1);
  assign frame_end = wrap && idx == IW'(NUM_DIGITS - 1);
  // scan counters: dwell SCAN_DIV cycles per digit, then step to the next digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else begin
      div <= wrap ? '0 : div + DW'(1);
      if (wrap) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1);
    end
  end
  // one-deep pending buffer; only swapped into the display on the frame boundary so a frame never tears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else if (valid_i && !pend_full) begin
      pend_data <= data_i;
      pend_dp   <= dp_i;
      pend_full <= 1'b1;
    end else if (frame_end && pend_full) begin
      disp_data <= pend_data;
      disp_dp   <= pend_dp;
      pend_full <= 1'b0;
    end
  end
  // lz[k] is set when nibbles k..NUM_DIGITS-1 are all zero
  always_comb begin
    acc = 1'b1;
    lz  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc   = acc && disp_data[4*k +: 4] == 4'h0;
      lz[k] = acc;
    end
  end
  // decode the active digit from registered state only, then apply blanking
  always_comb begin
    nib     = disp_data[4*idx +: 4];
    blanked = BLANK_LEADING != 0 && idx != '0 && lz[idx];
    seg     = blank_i || blanked ? 7'h00 : HEX[nib];
    dp      = blank_i || blanked ? 1'b0 : disp_dp[idx];
    sel     = blank_i ? '0 : NUM_DIGITS'(1) << idx;
  end
  assign seg_o     = ACTIVE_LOW_SEG != 0 ? ~seg : seg;
  assign dp_o      = ACTIVE_LOW_SEG != 0 ? ~dp : dp;
  assign dig_sel_o = ACTIVE_LOW_SEG != 0 ? ~sel : sel;
  assign dig_idx_o = idx;
  assign ready_o   = !pend_full;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed checks of scan timing, handshake, frame commit, blanking and polarity
module tb_ssd_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  logic [7:0]  a_data = '0;
  logic [1:0]  a_dp = '0, a_sel;
  logic        a_valid = 1'b0, a_blank = 1'b0, a_ready, a_dpo;
  logic [6:0]  a_seg;
  logic [0:0]  a_idx;
  logic [15:0] b_data = '0;
  logic [3:0]  b_dp = '0, b_sel;
  logic        b_valid = 1'b0, b_blank = 1'b0, b_ready, b_dpo;
  logic [6:0]  b_seg;
  logic [1:0]  b_idx;
  logic [7:0]  c_data = '0;
  logic [1:0]  c_dp = '0, c_sel;
  logic        c_valid = 1'b0, c_blank = 1'b0, c_ready, c_dpo;
  logic [6:0]  c_seg;
  logic [0:0]  c_idx;
  logic [6:0]  b_seen [4];
  logic        b_dps [4];
  ssd_scan_driver #(.NUM_DIGITS(2), .SCAN_DIV(4), .ACTIVE_LOW_SEG(0), .BLANK_LEADING(0)) u_a (
    .clk(clk), .rst(rst), .data_i(a_data), .dp_i(a_dp), .valid_i(a_valid), .ready_o(a_ready),
    .blank_i(a_blank), .seg_o(a_seg), .dp_o(a_dpo), .dig_sel_o(a_sel), .dig_idx_o(a_idx));
  ssd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW_SEG(0), .BLANK_LEADING(1)) u_b (
    .clk(clk), .rst(rst), .data_i(b_data), .dp_i(b_dp), .valid_i(b_valid), .ready_o(b_ready),
    .blank_i(b_blank), .seg_o(b_seg), .dp_o(b_dpo), .dig_sel_o(b_sel), .dig_idx_o(b_idx));
  ssd_scan_driver #(.NUM_DIGITS(2), .SCAN_DIV(4), .ACTIVE_LOW_SEG(1), .BLANK_LEADING(0)) u_c (
    .clk(clk), .rst(rst), .data_i(c_data), .dp_i(c_dp), .valid_i(c_valid), .ready_o(c_ready),
    .blank_i(c_blank), .seg_o(c_seg), .dp_o(c_dpo), .dig_sel_o(c_sel), .dig_idx_o(c_idx));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic load_b(input logic [15:0] d, input logic [3:0] p);
    int t;
    b_data = d;
    b_dp = p;
    b_valid = 1'b1;
    t = 0;
    while (!b_ready && t < 100) begin tick(); t++; end
    tick();
    b_valid = 1'b0;
    check("b_accepted", {31'd0, b_ready}, 32'd0);
    t = 0;
    while (!b_ready && t < 100) begin tick(); t++; end
    check("b_commit_in_time", {31'd0, t < 100}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      b_seen[b_idx] = b_seg;
      b_dps[b_idx] = b_dpo;
      tick();
    end
  endtask
  initial begin
    int t;
    #1 rst = 1'b1;
    #2;
    check("rst_seg", {25'd0, a_seg}, 32'h3F);
    check("rst_sel", {30'd0, a_sel}, 32'h1);
    check("rst_dp", {31'd0, a_dpo}, 32'd0);
    check("rst_ready", {31'd0, a_ready}, 32'd1);
    rst = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) begin
      check("idle_sel", {30'd0, a_sel}, c < 4 ? 32'h1 : 32'h2);
      check("idle_idx", {31'd0, a_idx}, c < 4 ? 32'd0 : 32'd1);
      check("idle_seg", {25'd0, a_seg}, 32'h3F);
      check("idle_ready", {31'd0, a_ready}, 32'd1);
      tick();
    end
    tick(2);
    a_data = 8'hA5;
    a_dp = 2'b10;
    a_valid = 1'b1;
    tick();
    a_data = 8'h3C;
    a_dp = 2'b00;
    check("load_ready_low", {31'd0, a_ready}, 32'd0);
    for (int c = 3; c < 8; c++) begin
      check("pend_ready", {31'd0, a_ready}, 32'd0);
      check("pend_seg_unchanged", {25'd0, a_seg}, 32'h3F);
      check("pend_dp_unchanged", {31'd0, a_dpo}, 32'd0);
      tick();
    end
    check("commit_ready", {31'd0, a_ready}, 32'd1);
    check("a5_d0_seg", {25'd0, a_seg}, 32'h6D);
    check("a5_d0_dp", {31'd0, a_dpo}, 32'd0);
    check("a5_d0_sel", {30'd0, a_sel}, 32'h1);
    tick();
    a_valid = 1'b0;
    check("bp_accepted", {31'd0, a_ready}, 32'd0);
    check("a5_still_d0", {25'd0, a_seg}, 32'h6D);
    tick(3);
    check("a5_d1_seg", {25'd0, a_seg}, 32'h77);
    check("a5_d1_dp", {31'd0, a_dpo}, 32'd1);
    check("a5_d1_sel", {30'd0, a_sel}, 32'h2);
    tick(4);
    check("3c_ready", {31'd0, a_ready}, 32'd1);
    check("3c_d0_seg", {25'd0, a_seg}, 32'h39);
    check("3c_d0_dp", {31'd0, a_dpo}, 32'd0);
    tick(4);
    check("3c_d1_seg", {25'd0, a_seg}, 32'h4F);
    tick(4);
    a_data = 8'h12;
    a_dp = 2'b01;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    check("pre_rst_ready", {31'd0, a_ready}, 32'd0);
    check("pre_rst_seg", {25'd0, a_seg}, 32'h39);
    #2 rst = 1'b1;
    #1;
    check("async_rst_seg", {25'd0, a_seg}, 32'h3F);
    check("async_rst_sel", {30'd0, a_sel}, 32'h1);
    check("async_rst_idx", {31'd0, a_idx}, 32'd0);
    check("async_rst_dp", {31'd0, a_dpo}, 32'd0);
    check("async_rst_ready", {31'd0, a_ready}, 32'd1);
    #1 rst = 1'b0;
    tick(8);
    check("post_rst_d0_seg", {25'd0, a_seg}, 32'h3F);
    check("post_rst_d0_dp", {31'd0, a_dpo}, 32'd0);
    tick(4);
    check("post_rst_d1_seg", {25'd0, a_seg}, 32'h3F);
    a_blank = 1'b1;
    #1;
    check("blank_seg", {25'd0, a_seg}, 32'h00);
    check("blank_sel", {30'd0, a_sel}, 32'h0);
    check("blank_dp", {31'd0, a_dpo}, 32'd0);
    a_blank = 1'b0;
    #1;
    check("unblank_sel", {30'd0, a_sel}, 32'h2);
    load_b(16'h0070, 4'b1000);
    check("lz70_d3_seg", {25'd0, b_seen[3]}, 32'h00);
    check("lz70_d3_dp", {31'd0, b_dps[3]}, 32'd0);
    check("lz70_d2_seg", {25'd0, b_seen[2]}, 32'h00);
    check("lz70_d1_seg", {25'd0, b_seen[1]}, 32'h07);
    check("lz70_d0_seg", {25'd0, b_seen[0]}, 32'h3F);
    load_b(16'h0000, 4'b0000);
    check("lz00_d3_seg", {25'd0, b_seen[3]}, 32'h00);
    check("lz00_d2_seg", {25'd0, b_seen[2]}, 32'h00);
    check("lz00_d1_seg", {25'd0, b_seen[1]}, 32'h00);
    check("lz00_d0_seg", {25'd0, b_seen[0]}, 32'h3F);
    c_data = 8'h88;
    c_dp = 2'b00;
    c_valid = 1'b1;
    t = 0;
    while (!c_ready && t < 100) begin tick(); t++; end
    tick();
    c_valid = 1'b0;
    t = 0;
    while (!c_ready && t < 100) begin tick(); t++; end
    check("c_commit_in_time", {31'd0, t < 100}, 32'd1);
    t = 0;
    while (c_idx != 1'b0 && t < 100) begin tick(); t++; end
    check("al_seg", {25'd0, c_seg}, 32'h00);
    check("al_sel", {30'd0, c_sel}, 32'h2);
    check("al_dp", {31'd0, c_dpo}, 32'd1);
    c_blank = 1'b1;
    #1;
    check("al_blank_seg", {25'd0, c_seg}, 32'h7F);
    check("al_blank_sel", {30'd0, c_sel}, 32'h3);
    check("al_blank_dp", {31'd0, c_dpo}, 32'd1);
    c_blank = 1'b0;
    #1;
    check("al_unblank_seg", {25'd0, c_seg}, 32'h00);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
